// File: rtl/block_spawn_ctrl.sv
// -----------------------------------------------------------------------------
// block_spawn_ctrl
// Obstacle scheduler for the runner game. A free-running 16-bit LFSR picks
// obstacle patterns and the random part of the empty gap that follows each
// obstacle. One 8-bit column is produced per accepted scroll tick and offered
// to the map shift register over a valid/ready handshake. The block also owns
// the IDLE/RUN/FROZEN run sequencing and the obstacle count for scoring.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous reset, active low
//   start         pulse: begin/restart a run (ignored while running)
//   pause         level: ignore scroll_tick while high
//   game_over     freeze generation, drop any pending column
//   scroll_tick   pulse: map scrolls by one column
//   col_ready     map shift register accepts the offered column
//   col_valid     col_data / col_is_block valid
//   col_data      column bitmap, bit7 = top row
//   col_is_block  col_data is an obstacle column
//   block_count   obstacles accepted this run, saturating
//   overrun       sticky: a tick arrived while a column was still pending
//   running       run state active
// -----------------------------------------------------------------------------
module block_spawn_ctrl #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned MIN_GAP       = 2,
    parameter int unsigned GAP_SPAN_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    input  logic        scroll_tick,
    input  logic        col_ready,
    output logic        col_valid,
    output logic [7:0]  col_data,
    output logic        col_is_block,
    output logic [15:0] block_count,
    output logic        overrun,
    output logic        running
);

    localparam int unsigned GAP_MAX = MIN_GAP + (1 << GAP_SPAN_LOG2) - 1;
    localparam int unsigned GW      = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [15:0]   lfsr_r;
    logic [GW-1:0] gap_cnt_r, gap_cnt_nxt_s;
    logic          col_valid_r, col_valid_nxt_s;
    logic [7:0]    col_data_r, col_data_nxt_s;
    logic          col_is_block_r, col_is_block_nxt_s;
    logic [15:0]   block_count_r, block_count_nxt_s;
    logic          overrun_r, overrun_nxt_s;

    logic          xfer_s;
    logic          tick_s;
    logic [7:0]    pattern_s;

    // Obstacle bitmap chosen by the two low LFSR bits; 8'h00 means "no obstacle".
    function automatic logic [7:0] pattern_of(input logic [1:0] sel);
        logic [7:0] p;
        case (sel)
            2'b00:   p = 8'hC6;
            2'b01:   p = 8'h3A;
            2'b10:   p = 8'hFC;
            2'b11:   p = 8'h00;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    // Fibonacci step, taps 16,14,13,11 (bit 16 is lfsr[15]).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign xfer_s    = col_valid_r & col_ready;
    assign tick_s    = scroll_tick & ~pause;
    assign pattern_s = pattern_of(lfsr_r[1:0]);

    // State register plus all registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            lfsr_r         <= LFSR_SEED;
            gap_cnt_r      <= {GW{1'b0}};
            col_valid_r    <= 1'b0;
            col_data_r     <= 8'h00;
            col_is_block_r <= 1'b0;
            block_count_r  <= 16'h0000;
            overrun_r      <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            lfsr_r         <= lfsr_step(lfsr_r);
            gap_cnt_r      <= gap_cnt_nxt_s;
            col_valid_r    <= col_valid_nxt_s;
            col_data_r     <= col_data_nxt_s;
            col_is_block_r <= col_is_block_nxt_s;
            block_count_r  <= block_count_nxt_s;
            overrun_r      <= overrun_nxt_s;
        end
    end

    // Next-state logic; game_over has priority over start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_FROZEN: begin
                if (start && !game_over) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_nxt_s = ST_FROZEN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Column generation, handshake and counters for the next cycle.
    always_comb begin
        gap_cnt_nxt_s      = gap_cnt_r;
        col_valid_nxt_s    = col_valid_r;
        col_data_nxt_s     = col_data_r;
        col_is_block_nxt_s = col_is_block_r;
        block_count_nxt_s  = block_count_r;
        overrun_nxt_s      = overrun_r;
        case (state_r)
            ST_RUN: begin
                if (game_over) begin
                    col_valid_nxt_s = 1'b0;
                end else begin
                    if (xfer_s && col_is_block_r && (block_count_r != 16'hFFFF)) begin
                        block_count_nxt_s = block_count_r + 16'd1;
                    end else begin
                        block_count_nxt_s = block_count_r;
                    end
                    if (tick_s) begin
                        // A column still waiting (and not leaving this cycle) wins over the tick.
                        if (col_valid_r && !col_ready) begin
                            overrun_nxt_s = 1'b1;
                        end else if (gap_cnt_r != {GW{1'b0}}) begin
                            col_valid_nxt_s    = 1'b1;
                            col_data_nxt_s     = 8'h00;
                            col_is_block_nxt_s = 1'b0;
                            gap_cnt_nxt_s      = gap_cnt_r - GW'(1);
                        end else begin
                            col_valid_nxt_s    = 1'b1;
                            col_data_nxt_s     = pattern_s;
                            col_is_block_nxt_s = (pattern_s != 8'h00);
                            if (pattern_s != 8'h00) begin
                                gap_cnt_nxt_s = GW'(MIN_GAP) + GW'(lfsr_r[GAP_SPAN_LOG2+1:2]);
                            end else begin
                                gap_cnt_nxt_s = {GW{1'b0}};
                            end
                        end
                    end else if (xfer_s) begin
                        col_valid_nxt_s = 1'b0;
                    end else begin
                        col_valid_nxt_s = col_valid_r;
                    end
                end
            end
            ST_IDLE, ST_FROZEN: begin
                if (start && !game_over) begin
                    block_count_nxt_s = 16'h0000;
                    overrun_nxt_s     = 1'b0;
                    gap_cnt_nxt_s     = GW'(MIN_GAP);
                    col_valid_nxt_s   = 1'b0;
                end else begin
                    col_valid_nxt_s   = 1'b0;
                end
            end
            default: begin
                col_valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign col_valid    = col_valid_r;
    assign col_data     = col_data_r;
    assign col_is_block = col_is_block_r;
    assign block_count  = block_count_r;
    assign overrun      = overrun_r;
    assign running      = (state_r == ST_RUN);

endmodule
